// File: rtl/hamming_encode_arbiter_pkg.sv
// Shared types and width helpers for the Hamming encoder arbiter slice.
package hamming_encode_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // Requester ID width; a single requester still gets one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Smallest r with 2^r >= k + r + 1 (single-error-correcting Hamming).
    function automatic int unsigned calc_code_bits(input int unsigned data_width);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < (data_width + r + 1)) r++;
        return r;
    endfunction

    function automatic int unsigned calc_coded_width(input int unsigned data_width);
        return data_width + calc_code_bits(data_width);
    endfunction

endpackage

// File: rtl/hamming_encode_arbiter_rsp_fifo.sv
// Synchronous response FIFO; read data comes straight from storage flops.
module hamming_rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // Storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/hamming_encode_arbiter.sv
// Round-robin sharing of one fixed-latency Hamming encoder among NUM_REQ
// requesters, with ID tagging and an in-order response FIFO.
module hamming_encode_arbiter
    import hamming_encode_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ENC_LATENCY = 1,
    parameter int unsigned RSP_DEPTH   = 4
) (
    input  logic                                     clk_i,
    input  logic                                     rst_n_i,
    input  logic                                     enable_i,
    input  logic [NUM_REQ-1:0]                       req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]       req_data_i,
    output logic [NUM_REQ-1:0]                       req_ready_o,
    output logic [DATA_WIDTH-1:0]                    enc_data_o,
    output logic                                     enc_valid_o,
    input  logic [calc_coded_width(DATA_WIDTH)-1:0]  enc_data_i,
    input  logic [calc_code_bits(DATA_WIDTH)-1:0]    enc_parity_i,
    input  logic                                     enc_valid_i,
    output logic                                     rsp_valid_o,
    input  logic                                     rsp_ready_i,
    output logic [id_width(NUM_REQ)-1:0]             rsp_id_o,
    output logic [calc_coded_width(DATA_WIDTH)-1:0]  rsp_data_o,
    output logic [calc_code_bits(DATA_WIDTH)-1:0]    rsp_parity_o,
    output logic                                     idle_o,
    output logic                                     err_o
);

    localparam int unsigned IW     = id_width(NUM_REQ);
    localparam int unsigned CW     = calc_coded_width(DATA_WIDTH);
    localparam int unsigned CB     = calc_code_bits(DATA_WIDTH);
    localparam int unsigned CR_W   = $clog2(RSP_DEPTH + 1);
    localparam int unsigned FIFO_W = IW + CW + CB;

    arb_state_e              state_q;
    arb_state_e              state_d;
    logic [IW-1:0]           ptr_q;
    logic [CR_W-1:0]         credit_q;
    logic [CR_W-1:0]         credit_d;
    logic [IW-1:0]           issue_id;
    logic [ENC_LATENCY-1:0]  tag_v;
    logic [IW-1:0]           tag_id [ENC_LATENCY];

    logic                    grant_ok;
    logic                    grant_found;
    logic [IW-1:0]           grant_id;
    logic                    hi_found;
    logic [IW-1:0]           hi_id;
    logic                    lo_found;
    logic [IW-1:0]           lo_id;
    logic                    pop;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic [FIFO_W-1:0]       fifo_rd_data;
    logic                    pipe_valid;

    assign pipe_valid  = tag_v[ENC_LATENCY-1];
    assign rsp_valid_o = !fifo_empty;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign {rsp_id_o, rsp_data_o, rsp_parity_o} = fifo_rd_data;

    // Round-robin pick: lowest valid index at/after the pointer, else lowest overall.
    always_comb begin
        hi_found    = 1'b0;
        hi_id       = '0;
        lo_found    = 1'b0;
        lo_id       = '0;
        req_ready_o = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (req_valid_i[i-1]) begin
                lo_found = 1'b1;
                lo_id    = IW'(i - 1);
                if (IW'(i - 1) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_id    = IW'(i - 1);
                end
            end
        end
        grant_ok    = (state_q == RUN) && enable_i &&
                      (credit_q < CR_W'(RSP_DEPTH)) && !fifo_full;
        grant_found = grant_ok && lo_found;
        grant_id    = hi_found ? hi_id : lo_id;
        if (grant_found) req_ready_o[grant_id] = 1'b1;
    end

    // Outstanding-word credit after this cycle's grant and pop.
    always_comb begin
        credit_d = credit_q;
        if (grant_found && !pop)      credit_d = credit_q + 1'b1;
        else if (!grant_found && pop) credit_d = credit_q - 1'b1;
    end

    // Next state; the drain check uses the post-update credit so IDLE is
    // reached the cycle after the last pop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (!enable_i) state_d = (credit_d != '0) ? DRAIN : IDLE;
            DRAIN: begin
                if (enable_i)             state_d = RUN;
                else if (credit_d == '0)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, credit, idle flag (held low in reset) and sticky error.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            credit_q <= '0;
            idle_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            idle_o   <= (state_d == IDLE);
            if (enc_valid_i != pipe_valid) err_o <= 1'b1;
        end
    end

    // Registered issue to the encoder and round-robin pointer advance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            enc_valid_o <= 1'b0;
            enc_data_o  <= '0;
            issue_id    <= '0;
            ptr_q       <= '0;
        end else begin
            enc_valid_o <= grant_found;
            if (grant_found) begin
                enc_data_o <= req_data_i[grant_id];
                issue_id   <= grant_id;
                ptr_q      <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

    // Tag pipe matching the encoder latency.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tag_v <= '0;
            for (int unsigned i = 0; i < ENC_LATENCY; i++) tag_id[i] <= '0;
        end else begin
            tag_v[0]  <= enc_valid_o;
            tag_id[0] <= issue_id;
            for (int unsigned i = 1; i < ENC_LATENCY; i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    hamming_rsp_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .wr_en   (pipe_valid),
        .wr_data ({tag_id[ENC_LATENCY-1], enc_data_i, enc_parity_i}),
        .rd_en   (rsp_ready_i),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_hamming_encode_arbiter.sv
// Directed bench for hamming_encode_arbiter with a behavioural encoder.
module tb_hamming_encode_arbiter;
    import hamming_encode_arbiter_pkg::*;

    localparam int unsigned NR    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned LAT   = 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = calc_coded_width(DW);
    localparam int unsigned CB    = calc_code_bits(DW);
    localparam int unsigned IW    = id_width(NR);

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   enable;
    logic [NR-1:0]          req_valid;
    logic [NR-1:0][DW-1:0]  req_data;
    logic [NR-1:0]          req_ready_o;
    logic [DW-1:0]          enc_data_o;
    logic                   enc_valid_o;
    logic [CW-1:0]          enc_data_i;
    logic [CB-1:0]          enc_parity_i;
    logic                   enc_valid_i;
    logic                   rsp_valid_o;
    logic                   rsp_ready;
    logic [IW-1:0]          rsp_id_o;
    logic [CW-1:0]          rsp_data_o;
    logic [CB-1:0]          rsp_parity_o;
    logic                   idle_o;
    logic                   err_o;
    logic                   inj;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    hamming_encode_arbiter #(
        .NUM_REQ     (NR),
        .DATA_WIDTH  (DW),
        .ENC_LATENCY (LAT),
        .RSP_DEPTH   (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .enable_i     (enable),
        .req_valid_i  (req_valid),
        .req_data_i   (req_data),
        .req_ready_o  (req_ready_o),
        .enc_data_o   (enc_data_o),
        .enc_valid_o  (enc_valid_o),
        .enc_data_i   (enc_data_i),
        .enc_parity_i (enc_parity_i),
        .enc_valid_i  (enc_valid_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id_o),
        .rsp_data_o   (rsp_data_o),
        .rsp_parity_o (rsp_parity_o),
        .idle_o       (idle_o),
        .err_o        (err_o)
    );

    // Hamming codeword: parity at power-of-two positions, data elsewhere.
    function automatic logic [CW-1:0] ham_cw(input logic [DW-1:0] d);
        logic [CW-1:0] cw;
        int unsigned   j;
        logic          par;
        cw = '0;
        j  = 0;
        for (int unsigned pos = 1; pos <= CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos-1] = d[j];
                j++;
            end
        end
        for (int unsigned p = 0; p < CB; p++) begin
            par = 1'b0;
            for (int unsigned pos = 1; pos <= CW; pos++)
                if ((pos & (32'd1 << p)) != 0) par = par ^ cw[pos-1];
            cw[(32'd1 << p) - 1] = par;
        end
        return cw;
    endfunction

    function automatic logic [CB-1:0] ham_par(input logic [CW-1:0] cw);
        logic [CB-1:0] p;
        for (int unsigned i = 0; i < CB; i++) p[i] = cw[(32'd1 << i) - 1];
        return p;
    endfunction

    function automatic logic [DW-1:0] dpat(input int unsigned id, input int unsigned n);
        return {8'hA5, 8'(id), 16'(n)};
    endfunction

    // One-cycle encoder model sharing the DUT reset; inj forces a stray valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_i  <= 1'b0;
            enc_data_i   <= '0;
            enc_parity_i <= '0;
        end else begin
            enc_valid_i  <= enc_valid_o | inj;
            enc_data_i   <= ham_cw(enc_data_o);
            enc_parity_i <= ham_par(ham_cw(enc_data_o));
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_checks(input string pfx);
        check_eq({pfx, "_req_ready"}, req_ready_o, '0);
        check_eq({pfx, "_enc_valid"}, enc_valid_o, '0);
        check_eq({pfx, "_enc_data"},  enc_data_o, '0);
        check_eq({pfx, "_rsp_valid"}, rsp_valid_o, '0);
        check_eq({pfx, "_rsp_id"},    rsp_id_o, '0);
        check_eq({pfx, "_rsp_data"},  rsp_data_o, '0);
        check_eq({pfx, "_rsp_par"},   rsp_parity_o, '0);
        check_eq({pfx, "_idle"},      idle_o, '0);
        check_eq({pfx, "_err"},       err_o, '0);
    endtask

    // g < 0: no grant expected; otherwise grant to g and queue its response.
    task automatic expect_grant(input string tag, input int g);
        logic [NR-1:0] m;
        m = '0;
        if (g >= 0) begin
            m[g] = 1'b1;
            exp_q.push_back('{IW'(g), req_data[g]});
        end
        check_eq(tag, req_ready_o, m);
    endtask

    // Compare the head response while valid; retire it when consumed.
    task automatic chk_rsp(input string pfx);
        exp_t e;
        if (rsp_valid_o) begin
            if (exp_q.size() == 0) begin
                check_eq({pfx, "_rsp_unexpected"}, rsp_valid_o, 1'b0);
            end else begin
                e = exp_q[0];
                check_eq({pfx, "_rsp_id"},   rsp_id_o, e.id);
                check_eq({pfx, "_rsp_data"}, rsp_data_o, ham_cw(e.data));
                check_eq({pfx, "_rsp_par"},  rsp_parity_o, ham_par(ham_cw(e.data)));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic wait_drain(input string pfx);
        for (int i = 0; i < 12 && exp_q.size() != 0; i++) begin
            tick();
            #1;
            chk_rsp(pfx);
        end
        check_eq({pfx, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int g2[12] = '{3, 0, 1, 2, 3, 0, 1, 2, -1, -1, -1, -1};
        int g3[10] = '{3, 0, 1, 2, -1, -1, -1, -1, -1, 3};
        int g4[6]  = '{0, 1, -1, -1, -1, -1};
        int i4[6]  = '{0, 0, 0, 0, 0, 1};

        rst_n     = 1'b0;
        enable    = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        inj       = 1'b0;
        #2;
        zero_checks("reset");
        #15;
        rst_n  = 1'b1;
        enable = 1'b1;

        // Single request from requester 2.
        tick();
        req_valid   = 4'b0100;
        req_data[2] = 32'h0000_0001;
        rsp_ready   = 1'b1;
        #1;
        check_eq("t1_grant", req_ready_o, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        check_eq("t1_enc_valid", enc_valid_o, 1'b1);
        check_eq("t1_enc_data", enc_data_o, 32'h1);
        tick();
        #1;
        check_eq("t1_enc_valid_once", enc_valid_o, 1'b0);
        check_eq("t1_rsp_not_yet", rsp_valid_o, 1'b0);
        tick();
        #1;
        check_eq("t1_rsp_valid", rsp_valid_o, 1'b1);
        check_eq("t1_rsp_id", rsp_id_o, 2);
        check_eq("t1_rsp_data", rsp_data_o, 38'h7);
        check_eq("t1_rsp_par", rsp_parity_o, 6'h3);
        tick();
        #1;
        check_eq("t1_rsp_popped", rsp_valid_o, 1'b0);

        // All requesters valid, consumer always ready: one grant per cycle.
        for (int c = 0; c < 12; c++) begin
            tick();
            for (int i = 0; i < NR; i++) req_data[i] = dpat(i, c);
            req_valid = (c < 8) ? '1 : '0;
            #1;
            expect_grant("t2_grant", g2[c]);
            check_eq("t2_rsp_valid", rsp_valid_o, (c >= 3 && c < 11));
            chk_rsp("t2");
        end
        check_eq("t2_drained", exp_q.size(), 0);

        // Consumer stalled: credit caps grants at the FIFO depth.
        for (int c = 0; c < 10; c++) begin
            tick();
            for (int i = 0; i < NR; i++) req_data[i] = dpat(i, 100 + c);
            req_valid = '1;
            rsp_ready = (c >= 8);
            #1;
            expect_grant("t3_grant", g3[c]);
            chk_rsp("t3");
        end
        tick();
        req_valid = '0;
        #1;
        chk_rsp("t3");
        wait_drain("t3");

        // Enable drops with two words in flight.
        for (int c = 0; c < 6; c++) begin
            tick();
            for (int i = 0; i < NR; i++) req_data[i] = dpat(i, 200 + c);
            req_valid = '1;
            enable    = (c < 2);
            #1;
            expect_grant("t4_grant", g4[c]);
            check_eq("t4_idle", idle_o, i4[c]);
            chk_rsp("t4");
        end
        check_eq("t4_drained", exp_q.size(), 0);

        // Stray encoder valid with nothing issued.
        tick();
        req_valid = '0;
        inj       = 1'b1;
        #1;
        tick();
        inj = 1'b0;
        #1;
        check_eq("t5_err_pre", err_o, 1'b0);
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            check_eq("t5_err_sticky", err_o, 1'b1);
            check_eq("t5_no_write", rsp_valid_o, 1'b0);
        end

        // Asynchronous reset in the middle of traffic.
        tick();
        enable    = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b1;
        repeat (4) tick();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        zero_checks("t6_reset");
        exp_q.delete();
        #12;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NR; i++) req_data[i] = dpat(i, 300);
        #1;
        expect_grant("t6_first_grant", 0);
        check_eq("t6_rsp_empty0", rsp_valid_o, 1'b0);
        tick();
        req_valid = '0;
        #1;
        check_eq("t6_rsp_empty1", rsp_valid_o, 1'b0);
        check_eq("t6_err_cleared", err_o, 1'b0);
        tick();
        #1;
        check_eq("t6_rsp_empty2", rsp_valid_o, 1'b0);
        tick();
        #1;
        check_eq("t6_rsp_valid", rsp_valid_o, 1'b1);
        chk_rsp("t6");
        check_eq("t6_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
